gfx_rom_arbiter: RTL and testbench
==================================

# gfx_rom_arbiter

Sequencer and two-port arbiter for the K051962 graphics ROM bank (K13/K19 lower 256Kx16 pair, J13/J19 upper 128Kx16 pair). It grants one requester at a time, decodes the H18 region bit into per-pair chip enables, and holds the 16-bit ROMs enabled for a programmable number of wait cycles covering their 70 ns access time. It returns a 32-bit word from the selected pair. It sits between the tile-fetch path (port A, high priority) and the CPU/test readback path (port B, low priority).

## Interface
- ACC_CYCLES, 5: clock cycles the ROM pair is enabled before data is sampled; legal range 2..15.
- B_STARVE_MAX, 4: consecutive A grants allowed while B is pending before B is forced; legal range 1..15.
- CLK  in  1  single clock; all state changes on the rising edge.
- RESETn  in  1  synchronous, active-low reset.
- A_REQ  in  1  port A request, level; held until A_ACK.
- A_ADDR  in  19  port A word address; bit 18 = H18 region select.
- A_ACK  out  1  one-cycle pulse; DOUT and ERR valid in that cycle.
- B_REQ, B_ADDR, B_ACK  in/in/out  1/19/1  port B, same rules as port A.
- DOUT  out  32  read data: {K13,K19} when H18=0, {J13,J19} when H18=1.
- ERR  out  1  qualifies the ack; set when H18=1 and addr[17]=1 (outside the 128K upper range, mirrored).
- ROM_LO_ADDR  out  18  shared address for K13/K19.
- ROM_LO_CEn  out  1  chip enable for K13/K19, active low.
- ROM_HI_ADDR  out  17  shared address for J13/J19.
- ROM_HI_CEn  out  1  chip enable for J13/J19, active low.
- ROM_OEn  out  1  output enable for all four ROMs, active low.
- ROM_K13_D, ROM_K19_D, ROM_J13_D, ROM_J19_D  in  16 each  ROM data buses; may be Z when deselected.

## Operation
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE, when any request is pending:
  - Choose a winner (see arbitration) and latch its address and source.
  - Drive the ROM address, assert the CEn of the decoded pair only, and assert ROM_OEn.
  - Load the wait counter with ACC_CYCLES-1 and go to ACCESS.
- ACCESS: decrement the counter. At zero, capture the selected pair's data into DOUT and pulse the winner's ACK with ERR. Deassert both CEn and ROM_OEn, then go to RECOVER.
- RECOVER: one cycle with all ROMs deselected (bus turnaround), then IDLE.
- Arbitration:
  - A wins by default.
  - The starve counter increments on each A grant made while B_REQ=1, and clears whenever B_REQ=0 or B is granted.
  - When the counter equals B_STARVE_MAX, B wins the next arbitration even if A is pending.
- Upper region: when H18=1, only addr[16:0] reaches ROM_HI_ADDR. Bit 17 is ignored (mirror) and reported on ERR.
- ROM address outputs hold their last value while idle. DOUT holds its value between acks.
- A request that is still high in IDLE after its ack is treated as a new access. Dropping REQ before ACK is illegal (bench assertion).

## Timing
- Reset values: A_ACK=0, B_ACK=0, ERR=0, DOUT=0, ROM_LO_CEn=1, ROM_HI_CEn=1, ROM_OEn=1, ROM_*_ADDR=0, state IDLE, starve counter 0.
- Access sequence, where edge E0 is the grant edge (REQ sampled high in IDLE):
  - CEn and OEn go low after E0.
  - ACK, DOUT and ERR are valid in the cycle after edge E0+ACC_CYCLES.
  - RECOVER occupies that same cycle.
  - The earliest next grant is edge E0+ACC_CYCLES+2.
- Back-to-back throughput: one access per ACC_CYCLES+2 cycles.
- Simultaneous A_REQ and B_REQ in IDLE: A wins unless the starve counter equals B_STARVE_MAX.
- Address changes while a request is waiting (ungranted) are permitted. The address is sampled only at the grant edge.
- RESETn low mid-access:
  - Next edge forces the reset values above and aborts the access.
  - No ACK is issued.
  - Requesters must re-request.

## Configuration
- GFX_ROM_LAST_HIT_EN defined: one-entry cache of the last completed address (19 bits) and its data.
  - In IDLE, a winner whose address equals the valid cached address gets its ACK on the edge after the grant (latency 1) with the cached DOUT and ERR.
  - No ROM enables toggle on a hit, and there is no RECOVER cycle.
  - The cache entry is invalidated by reset.
- GFX_ROM_LAST_HIT_EN undefined: every grant performs a full ROM access. No cache registers are present.

## Structure
- Package gfx_rom_pkg holds:
  - the state enum (IDLE, ACCESS, RECOVER);
  - the address widths LO_AW=18, HI_AW=17, REQ_AW=19;
  - the defaults for ACC_CYCLES and B_STARVE_MAX.
- Sub-module gfx_rom_prio_sel contains the fixed-priority-with-starvation-guard selector and its starve counter. It is purely the grant decision and is reused by other shared-ROM ports.

## Test plan
- Reset, then A_REQ with A_ADDR=19'h00010 -> ROM_LO_CEn low and ROM_HI_CEn high for 5 cycles; A_ACK pulses after edge E0+5 with DOUT={K13[0x10],K19[0x10]} and ERR=0.
- B_REQ with B_ADDR=19'h40123 -> ROM_HI_ADDR=17'h00123 and ROM_HI_CEn low; B_ACK with DOUT={J13[0x123],J19[0x123]}. Address 19'h60123 returns the same data with ERR=1.
- A and B both requesting continuously with B_STARVE_MAX=4 -> grant order A,A,A,A,B repeating; each grant spaced 7 cycles apart.
- RESETn low for one cycle at ACCESS cycle 3 -> no ACK issued, all CEn/OEn high next cycle, state IDLE; a re-request completes normally.
- With GFX_ROM_LAST_HIT_EN, A reads 19'h00010 twice -> second ACK one cycle after grant with no CEn activity; an intervening reset forces a full access.

Source files
------------

// File: rtl/gfx_rom_pkg.sv
// gfx_rom_pkg: shared states, widths and defaults for the K051962 graphics ROM arbiter.
package gfx_rom_pkg;

    localparam int LO_AW                = 18;
    localparam int HI_AW                = 17;
    localparam int REQ_AW               = 19;
    localparam int ACC_CYCLES_DEFAULT   = 5;
    localparam int B_STARVE_MAX_DEFAULT = 4;
    localparam int WAIT_CW              = 4;
    localparam int STARVE_CW            = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } arbState_t;

    // Upper-pair addresses with bit 17 set fall outside the 128K parts and mirror.
    function automatic logic mirrorErr(input logic h18, input logic bit17);
        return h18 & bit17;
    endfunction

endpackage

// File: rtl/gfx_rom_prio_sel.sv
// gfx_rom_prio_sel: fixed A-over-B priority with a starvation guard for port B.
module gfx_rom_prio_sel
    import gfx_rom_pkg::*;
#(
    parameter int STARVE_MAX = B_STARVE_MAX_DEFAULT
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_arb_en,
    input  logic i_a_req,
    input  logic i_b_req,
    output logic o_grant_a,
    output logic o_grant_b
);

    logic [STARVE_CW-1:0] r_starveCnt;
    logic                 w_starved;

    assign w_starved = (r_starveCnt == STARVE_CW'(STARVE_MAX));

    // Grant decision: A by default, B when alone or once A has had its quota of grants.
    always_comb begin
        o_grant_a = 1'b0;
        o_grant_b = 1'b0;
        if (i_arb_en) begin
            if (i_b_req && (!i_a_req || w_starved)) begin
                o_grant_b = 1'b1;
            end else if (i_a_req) begin
                o_grant_a = 1'b1;
            end
        end
    end

    // Count A grants taken while B waits; any cycle without B pending, or a B grant, clears it.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_starveCnt <= '0;
        end else if (!i_b_req || o_grant_b) begin
            r_starveCnt <= '0;
        end else if (o_grant_a) begin
            r_starveCnt <= r_starveCnt + STARVE_CW'(1);
        end
    end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: two-port sequencer for the K13/K19 (lower) and J13/J19 (upper) ROM pairs.
// Optional one-entry last-hit cache enabled by defining GFX_ROM_LAST_HIT_EN.
module gfx_rom_arbiter
    import gfx_rom_pkg::*;
#(
    parameter int ACC_CYCLES   = ACC_CYCLES_DEFAULT,
    parameter int B_STARVE_MAX = B_STARVE_MAX_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_a_req,
    input  logic [REQ_AW-1:0] i_a_addr,
    output logic              o_a_ack,
    input  logic              i_b_req,
    input  logic [REQ_AW-1:0] i_b_addr,
    output logic              o_b_ack,
    output logic [31:0]       o_dout,
    output logic              o_err,
    output logic [LO_AW-1:0]  o_rom_lo_addr,
    output logic              o_rom_lo_cen,
    output logic [HI_AW-1:0]  o_rom_hi_addr,
    output logic              o_rom_hi_cen,
    output logic              o_rom_oen,
    input  logic [15:0]       i_rom_k13_d,
    input  logic [15:0]       i_rom_k19_d,
    input  logic [15:0]       i_rom_j13_d,
    input  logic [15:0]       i_rom_j19_d
);

    arbState_t            r_state;
    arbState_t            w_nextState;
    logic [WAIT_CW-1:0]   r_waitCnt;
    logic                 r_srcB;
    logic                 r_selHi;
    logic                 r_reqErr;
    logic                 r_aAck;
    logic                 r_bAck;
    logic [31:0]          r_dout;
    logic                 r_err;
    logic [LO_AW-1:0]     r_loAddr;
    logic [HI_AW-1:0]     r_hiAddr;
    logic                 r_loCen;
    logic                 r_hiCen;
    logic                 r_oen;

    logic                 w_grantA;
    logic                 w_grantB;
    logic                 w_anyGrant;
    logic                 w_done;
    logic [REQ_AW-1:0]    w_winAddr;
    logic [31:0]          w_romData;
    logic                 w_lookupHit;
    logic                 w_hitActive;
    logic [31:0]          w_cacheData;

    gfx_rom_prio_sel #(
        .STARVE_MAX (B_STARVE_MAX)
    ) u_prioSel (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_arb_en  (r_state == IDLE),
        .i_a_req   (i_a_req),
        .i_b_req   (i_b_req),
        .o_grant_a (w_grantA),
        .o_grant_b (w_grantB)
    );

    assign w_anyGrant = w_grantA | w_grantB;
    assign w_winAddr  = w_grantB ? i_b_addr : i_a_addr;
    assign w_done     = (r_state == ACCESS) && (r_waitCnt == '0);
    assign w_romData  = r_selHi ? {i_rom_j13_d, i_rom_j19_d} : {i_rom_k13_d, i_rom_k19_d};

`ifdef GFX_ROM_LAST_HIT_EN
    logic                 r_cacheValid;
    logic [REQ_AW-1:0]    r_cacheAddr;
    logic [31:0]          r_cacheData;
    logic [REQ_AW-1:0]    r_reqAddr;
    logic                 r_hit;

    assign w_lookupHit = r_cacheValid && (r_cacheAddr == w_winAddr);
    assign w_hitActive = r_hit;
    assign w_cacheData = r_cacheData;

    // Remember the last ROM-backed access so an identical re-read skips the ROM entirely.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cacheValid <= 1'b0;
            r_cacheAddr  <= '0;
            r_cacheData  <= '0;
            r_reqAddr    <= '0;
            r_hit        <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_anyGrant) begin
                r_reqAddr <= w_winAddr;
                r_hit     <= w_lookupHit;
            end
            if (w_done && !r_hit) begin
                r_cacheValid <= 1'b1;
                r_cacheAddr  <= r_reqAddr;
                r_cacheData  <= w_romData;
            end
        end
    end
`else
    assign w_lookupHit = 1'b0;
    assign w_hitActive = 1'b0;
    assign w_cacheData = '0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a hit returns straight to IDLE because the ROM bus was never driven.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyGrant) w_nextState = ACCESS;
            ACCESS:  if (r_waitCnt == '0) w_nextState = w_hitActive ? IDLE : RECOVER;
            RECOVER: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: latch the winner, drive the decoded pair, count the access time, then capture and ack.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_waitCnt <= '0;
            r_srcB    <= 1'b0;
            r_selHi   <= 1'b0;
            r_reqErr  <= 1'b0;
            r_aAck    <= 1'b0;
            r_bAck    <= 1'b0;
            r_dout    <= '0;
            r_err     <= 1'b0;
            r_loAddr  <= '0;
            r_hiAddr  <= '0;
            r_loCen   <= 1'b1;
            r_hiCen   <= 1'b1;
            r_oen     <= 1'b1;
        end else begin
            r_aAck <= 1'b0;
            r_bAck <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyGrant) begin
                        r_srcB   <= w_grantB;
                        r_selHi  <= w_winAddr[REQ_AW-1];
                        r_reqErr <= mirrorErr(w_winAddr[REQ_AW-1], w_winAddr[REQ_AW-2]);
                        if (w_lookupHit) begin
                            r_waitCnt <= '0;
                        end else begin
                            r_waitCnt <= WAIT_CW'(ACC_CYCLES - 1);
                            r_oen     <= 1'b0;
                            if (w_winAddr[REQ_AW-1]) begin
                                r_hiAddr <= w_winAddr[HI_AW-1:0];
                                r_hiCen  <= 1'b0;
                            end else begin
                                r_loAddr <= w_winAddr[LO_AW-1:0];
                                r_loCen  <= 1'b0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (r_waitCnt == '0) begin
                        r_aAck  <= !r_srcB;
                        r_bAck  <= r_srcB;
                        r_dout  <= w_hitActive ? w_cacheData : w_romData;
                        r_err   <= r_reqErr;
                        r_loCen <= 1'b1;
                        r_hiCen <= 1'b1;
                        r_oen   <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt - WAIT_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_a_ack       = r_aAck;
    assign o_b_ack       = r_bAck;
    assign o_dout        = r_dout;
    assign o_err         = r_err;
    assign o_rom_lo_addr = r_loAddr;
    assign o_rom_lo_cen  = r_loCen;
    assign o_rom_hi_addr = r_hiAddr;
    assign o_rom_hi_cen  = r_hiCen;
    assign o_rom_oen     = r_oen;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// tb_gfx_rom_arbiter: directed and randomized bench for gfx_rom_arbiter with a
// transaction-schedule reference model (honours GFX_ROM_LAST_HIT_EN when defined).
module tb_gfx_rom_arbiter;

    localparam int ACC  = 5;
    localparam int SMAX = 4;
`ifdef GFX_ROM_LAST_HIT_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif
    localparam int HIT_LAT    = CACHE_EN ? 2 : ACC + 1;
    localparam int HIT_LO_LOW = CACHE_EN ? 0 : ACC;

    logic        clk = 1'b0;
    logic        resetn;
    logic        aReq, bReq;
    logic [18:0] aAddr, bAddr;
    logic        aAck, bAck, err;
    logic [31:0] dout;
    logic [17:0] romLoAddr;
    logic [16:0] romHiAddr;
    logic        romLoCen, romHiCen, romOen;
    logic [15:0] romK13, romK19, romJ13, romJ19;

    always #5 clk = ~clk;

    gfx_rom_arbiter #(.ACC_CYCLES(ACC), .B_STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_resetn(resetn),
        .i_a_req(aReq), .i_a_addr(aAddr), .o_a_ack(aAck),
        .i_b_req(bReq), .i_b_addr(bAddr), .o_b_ack(bAck),
        .o_dout(dout), .o_err(err),
        .o_rom_lo_addr(romLoAddr), .o_rom_lo_cen(romLoCen),
        .o_rom_hi_addr(romHiAddr), .o_rom_hi_cen(romHiCen), .o_rom_oen(romOen),
        .i_rom_k13_d(romK13), .i_rom_k19_d(romK19),
        .i_rom_j13_d(romJ13), .i_rom_j19_d(romJ19)
    );

    // ROM contents: address-derived patterns, buses float when the pair is not enabled.
    function automatic logic [15:0] k13F(input logic [17:0] a);
        return a[15:0] ^ 16'h1300 ^ {a[17:16], 14'h0};
    endfunction
    function automatic logic [15:0] k19F(input logic [17:0] a);
        return a[15:0] ^ 16'h1900 ^ {a[17:16], 14'h0};
    endfunction
    function automatic logic [15:0] j13F(input logic [16:0] a);
        return a[15:0] ^ 16'hA000 ^ {a[16], 15'h0};
    endfunction
    function automatic logic [15:0] j19F(input logic [16:0] a);
        return a[15:0] ^ 16'hB000 ^ {a[16], 15'h0};
    endfunction

    assign romK13 = (!romLoCen && !romOen) ? k13F(romLoAddr) : 16'hzzzz;
    assign romK19 = (!romLoCen && !romOen) ? k19F(romLoAddr) : 16'hzzzz;
    assign romJ13 = (!romHiCen && !romOen) ? j13F(romHiAddr) : 16'hzzzz;
    assign romJ19 = (!romHiCen && !romOen) ? j19F(romHiAddr) : 16'hzzzz;

    // Word a requester should receive for a 19-bit address.
    function automatic logic [31:0] wordFor(input logic [18:0] a);
        if (a[18]) return {j13F(a[16:0]), j19F(a[16:0])};
        return {k13F(a[17:0]), k19F(a[17:0])};
    endfunction

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: each grant schedules its enable window, ack edge and next free edge.
    int          edgeNum  = 0;
    int          mFree    = 0;
    int          mAckEdge = 0;
    int          mStarve  = 0;
    bit          mActive  = 1'b0;
    bit          mSrcB    = 1'b0;
    bit          mHit     = 1'b0;
    logic [18:0] mAddr    = '0;
    bit          cValid   = 1'b0;
    logic [18:0] cAddr    = '0;
    bit          eAckA    = 1'b0;
    bit          eAckB    = 1'b0;
    logic [31:0] eDout    = '0;
    logic        eErr     = 1'b0;
    logic [17:0] eLo      = '0;
    logic [16:0] eHi      = '0;

    always @(posedge clk) begin
        bit wB;
        edgeNum++;
        eAckA = 1'b0;
        eAckB = 1'b0;
        if (!resetn) begin
            mActive = 1'b0;
            mFree   = edgeNum + 1;
            mStarve = 0;
            cValid  = 1'b0;
            eDout   = '0;
            eErr    = 1'b0;
            eLo     = '0;
            eHi     = '0;
        end else begin
            if (mActive && edgeNum == mAckEdge) begin
                eDout   = wordFor(mAddr);
                eErr    = mAddr[18] & mAddr[17];
                eAckA   = !mSrcB;
                eAckB   = mSrcB;
                cValid  = 1'b1;
                cAddr   = mAddr;
                mActive = 1'b0;
            end
            if (!mActive && edgeNum >= mFree && (aReq || bReq)) begin
                wB = bReq && (!aReq || mStarve == SMAX);
                if (!bReq || wB) mStarve = 0;
                else             mStarve++;
                mAddr    = wB ? bAddr : aAddr;
                mSrcB    = wB;
                mHit     = CACHE_EN && cValid && (cAddr == mAddr);
                mAckEdge = edgeNum + (mHit ? 1 : ACC);
                mFree    = mHit ? edgeNum + 2 : edgeNum + ACC + 2;
                mActive  = 1'b1;
                if (!mHit) begin
                    if (mAddr[18]) eHi = mAddr[16:0];
                    else           eLo = mAddr[17:0];
                end
            end else if (!bReq) begin
                mStarve = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic expLoCen, expHiCen;
        if (checkEn) begin
            expLoCen = !(mActive && !mHit && !mAddr[18]);
            expHiCen = !(mActive && !mHit && mAddr[18]);
            checkOutput("aAck", 32'(aAck), 32'(eAckA));
            checkOutput("bAck", 32'(bAck), 32'(eAckB));
            checkOutput("loCen", 32'(romLoCen), 32'(expLoCen));
            checkOutput("hiCen", 32'(romHiCen), 32'(expHiCen));
            checkOutput("oen", 32'(romOen), 32'(expLoCen & expHiCen));
            checkOutput("dout", dout, eDout);
            checkOutput("loAddr", 32'(romLoAddr), 32'(eLo));
            checkOutput("hiAddr", 32'(romHiAddr), 32'(eHi));
            if (eAckA || eAckB) checkOutput("err", 32'(err), 32'(eErr));
        end
    end

    task automatic applyStimulus(input bit portB, input logic [18:0] addr);
        @(negedge clk);
        if (portB) begin bAddr = addr; bReq = 1'b1; end
        else       begin aAddr = addr; aReq = 1'b1; end
    endtask

    // Wait for this port's ack, measuring latency and enable activity, then release the request.
    task automatic waitAck(input bit portB, output int lat, output int loLow, output int hiLow,
                           output logic [16:0] firstHi);
        bit seen;
        seen = 1'b0; lat = 0; loLow = 0; hiLow = 0; firstHi = '0;
        while (!seen && lat < 50) begin
            @(negedge clk);
            lat++;
            if (lat == 1) firstHi = romHiAddr;
            if (!romLoCen) loLow++;
            if (!romHiCen) hiLow++;
            seen = portB ? bAck : aAck;
        end
        if (!seen) checkOutput("ackTimeout", 32'(seen), 32'd1);
        if (portB) bReq = 1'b0; else aReq = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
    endtask

    function automatic logic [18:0] randAddr();
        case ($urandom_range(0, 5))
            0:       return 19'h00010;
            1:       return 19'h40123;
            2:       return 19'h60123;
            3:       return {1'b0, 18'($urandom)};
            4:       return {1'b1, 18'($urandom)};
            default: return 19'h3FFFF;
        endcase
    endfunction

    // Random requester: releases only on its own ack, sometimes re-requesting immediately.
    task automatic stepPort(input bit portB, input bit stopping);
        logic req, ack;
        req = portB ? bReq : aReq;
        ack = portB ? bAck : aAck;
        if (req) begin
            if (ack) begin
                if (!stopping && $urandom_range(0, 1) == 1) begin
                    if (portB) bAddr = randAddr(); else aAddr = randAddr();
                end else begin
                    if (portB) bReq = 1'b0; else aReq = 1'b0;
                end
            end
        end else if (!stopping && $urandom_range(0, 2) == 0) begin
            if (portB) begin bAddr = randAddr(); bReq = 1'b1; end
            else       begin aAddr = randAddr(); aReq = 1'b1; end
        end
    endtask

    initial begin
        int lat, loLow, hiLow, nAcks, cyc, lastCyc, ackCnt;
        logic [16:0] firstHi;
        resetn = 1'b0; aReq = 1'b0; bReq = 1'b0; aAddr = '0; bAddr = '0;

        @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rstAck", 32'(aAck | bAck), 32'd0);
        checkOutput("rstCen", 32'({romLoCen, romHiCen, romOen}), 32'h7);
        checkOutput("rstDout", dout, 32'h0);
        resetn = 1'b1;

        $display("[TB] lower pair read from port A");
        applyStimulus(1'b0, 19'h00010);
        waitAck(1'b0, lat, loLow, hiLow, firstHi);
        checkOutput("aLatency", 32'(lat), 32'd6);
        checkOutput("aLoCenCycles", 32'(loLow), 32'd5);
        checkOutput("aHiCenCycles", 32'(hiLow), 32'd0);
        checkOutput("aData", dout, 32'h1310_1910);
        checkOutput("aErr", 32'(err), 32'd0);

        $display("[TB] upper pair read from port B, in range and mirrored");
        applyStimulus(1'b1, 19'h40123);
        waitAck(1'b1, lat, loLow, hiLow, firstHi);
        checkOutput("bHiAddr", 32'(firstHi), 32'h00123);
        checkOutput("bHiCenCycles", 32'(hiLow), 32'd5);
        checkOutput("bLoCenCycles", 32'(loLow), 32'd0);
        checkOutput("bData", dout, 32'hA123_B123);
        checkOutput("bErr", 32'(err), 32'd0);
        applyStimulus(1'b1, 19'h60123);
        waitAck(1'b1, lat, loLow, hiLow, firstHi);
        checkOutput("mirrorHiAddr", 32'(firstHi), 32'h00123);
        checkOutput("mirrorData", dout, 32'hA123_B123);
        checkOutput("mirrorErr", 32'(err), 32'd1);

        $display("[TB] starvation guard with both ports requesting");
        pulseReset();
        @(negedge clk);
        aAddr = 19'h00200; bAddr = 19'h40300; aReq = 1'b1; bReq = 1'b1;
        nAcks = 0; cyc = 0; lastCyc = 0;
        while (nAcks < 11 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (aAck || bAck) begin
                checkOutput($sformatf("grantOrder%0d", nAcks), 32'(bAck), 32'((nAcks % 5) == 4));
                if (nAcks > 0) checkOutput($sformatf("grantSpacing%0d", nAcks), 32'(cyc - lastCyc), 32'(ACC + 2));
                lastCyc = cyc;
                if (aAck) begin
                    aAddr = aAddr + 19'd1;
                    if (nAcks >= 9) aReq = 1'b0;
                end else begin
                    bAddr = bAddr + 19'd1;
                    if (nAcks >= 9) bReq = 1'b0;
                end
                nAcks++;
            end
        end
        if (nAcks < 11) checkOutput("starveTimeout", 32'(nAcks), 32'd11);
        aReq = 1'b0; bReq = 1'b0;

        $display("[TB] reset in the middle of an access");
        applyStimulus(1'b0, 19'h00055);
        @(negedge clk); @(negedge clk); @(negedge clk);
        checkOutput("preResetLoCen", 32'(romLoCen), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1; aReq = 1'b0;
        checkOutput("abortCen", 32'({romLoCen, romHiCen, romOen}), 32'h7);
        checkOutput("abortAck", 32'(aAck), 32'd0);
        ackCnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (aAck || bAck) ackCnt++;
        end
        checkOutput("abortNoAck", 32'(ackCnt), 32'd0);
        applyStimulus(1'b0, 19'h00055);
        waitAck(1'b0, lat, loLow, hiLow, firstHi);
        checkOutput("reReqLatency", 32'(lat), 32'd6);
        checkOutput("reReqData", dout, 32'h1355_1955);

        $display("[TB] repeated read of the same address");
        applyStimulus(1'b0, 19'h00010);
        waitAck(1'b0, lat, loLow, hiLow, firstHi);
        checkOutput("firstReadLatency", 32'(lat), 32'd6);
        applyStimulus(1'b0, 19'h00010);
        waitAck(1'b0, lat, loLow, hiLow, firstHi);
        checkOutput("repeatLatency", 32'(lat), 32'(HIT_LAT));
        checkOutput("repeatLoCenCycles", 32'(loLow), 32'(HIT_LO_LOW));
        checkOutput("repeatData", dout, 32'h1310_1910);
        pulseReset();
        applyStimulus(1'b0, 19'h00010);
        waitAck(1'b0, lat, loLow, hiLow, firstHi);
        checkOutput("postResetLatency", 32'(lat), 32'd6);
        checkOutput("postResetLoCenCycles", 32'(loLow), 32'd5);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            stepPort(1'b0, 1'b0);
            stepPort(1'b1, 1'b0);
        end
        cyc = 0;
        while ((aReq || bReq) && cyc < 200) begin
            @(negedge clk);
            stepPort(1'b0, 1'b1);
            stepPort(1'b1, 1'b1);
            cyc++;
        end
        if (aReq || bReq) checkOutput("drainTimeout", 32'({aReq, bReq}), 32'd0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
